// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader
// Configuration-side driver for a chain of fracturable LUTs. A serial
// bitstream (MSB first, one bit per accepted transfer) is shifted into a
// CFG_W-bit config word. Once a word is complete, the loader asserts the
// matching one-hot config enable for one cclk cycle so that LUT latches it.
// After NUM_LUTS words the loader parks in DONE until the next start.
//
// Optional feature (compile-time macro LUT_CFG_PARITY_EN): each word is
// followed by one even-parity bit. A mismatch raises err, suppresses the
// commit of this and every later LUT, and ends the sequence in DONE.
// Without the macro there is no parity state and err is tied low.
//
// Ports
//   cclk        configuration clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle pulse, begins a load (honoured in IDLE/DONE only)
//   bit_in      serial config bit, MSB of each word first
//   bit_valid   bit_in is valid this cycle
//   bit_ready   loader accepts a bit (transfer = bit_valid && bit_ready)
//   config_out  assembled word, shared by every LUT's config_in
//   cen_out     one-hot registered config enable, bit i targets LUT i
//   busy        high from start acceptance until DONE
//   done        sticky, high once the last LUT is committed
//   err         sticky parity error flag
module lut_cfg_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2**INPUTS,
    parameter int CFG_W    = 2*MEM_SIZE+1,
    parameter int NUM_LUTS = 4
) (
    input  logic                cclk,
    input  logic                rst,
    input  logic                start,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                bit_ready,
    output logic [CFG_W-1:0]    config_out,
    output logic [NUM_LUTS-1:0] cen_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
`ifdef LUT_CFG_PARITY_EN
        S_PARITY,
`endif
        S_COMMIT,
        S_DONE
    } state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             last_bit;
    logic             last_lut;

    assign last_bit = (cnt == CNT_W'(CFG_W - 1));
    assign last_lut = (idx == IDX_W'(NUM_LUTS - 1));

`ifdef LUT_CFG_PARITY_EN
    logic err_q;
    logic parity_ok;

    // Even parity: data bits plus the parity bit must hold an even count of ones.
    function automatic logic even_parity_ok(input logic [CFG_W-1:0] word,
                                            input logic             pbit);
        return ~(^{word, pbit});
    endfunction

    assign parity_ok = even_parity_ok(config_out, bit_in);
    assign err       = err_q;
`else
    assign err = 1'b0;
`endif

    // State register
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt_state;
    end

    // Next-state and state-decoded handshake/status outputs
    always_comb begin
        nxt_state = state;
        bit_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) nxt_state = S_SHIFT;
            end
            S_SHIFT: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                // bit_ready is constant 1 here, so bit_valid alone marks a transfer
                if (bit_valid && last_bit) begin
`ifdef LUT_CFG_PARITY_EN
                    nxt_state = S_PARITY;
`else
                    nxt_state = S_COMMIT;
`endif
                end
            end
`ifdef LUT_CFG_PARITY_EN
            S_PARITY: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (bit_valid) nxt_state = parity_ok ? S_COMMIT : S_DONE;
            end
`endif
            S_COMMIT: begin
                busy      = 1'b1;
                nxt_state = last_lut ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) nxt_state = S_SHIFT;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Datapath: shift register, counters, registered enable
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            config_out <= '0;
            cen_out    <= '0;
            cnt        <= '0;
            idx        <= '0;
`ifdef LUT_CFG_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // Enable is registered on entry to COMMIT so it is high exactly
            // for the COMMIT cycle, while config_out is frozen.
            cen_out <= (nxt_state == S_COMMIT) ? (NUM_LUTS'(1) << idx) : '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt <= '0;
                        idx <= '0;
`ifdef LUT_CFG_PARITY_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    if (bit_valid) begin
                        config_out <= {config_out[CFG_W-2:0], bit_in};
                        cnt        <= cnt + CNT_W'(1);
                    end
                end
`ifdef LUT_CFG_PARITY_EN
                S_PARITY: begin
                    if (bit_valid && !parity_ok) err_q <= 1'b1;
                end
`endif
                S_COMMIT: begin
                    if (!last_lut) begin
                        idx <= idx + IDX_W'(1);
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
module tb_lut_cfg_loader;
    localparam int CFG_W    = 33;
    localparam int NUM_LUTS = 4;
`ifdef LUT_CFG_PARITY_EN
    localparam int WORD_CYC = CFG_W + 2;
`else
    localparam int WORD_CYC = CFG_W + 1;
`endif

    logic                cclk = 1'b0;
    logic                rst, start, bit_in, bit_valid;
    logic                bit_ready, busy, done, err;
    logic [CFG_W-1:0]    config_out;
    logic [NUM_LUTS-1:0] cen_out;

    lut_cfg_loader #(.INPUTS(4), .NUM_LUTS(NUM_LUTS)) dut (
        .cclk(cclk), .rst(rst), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .config_out(config_out),
        .cen_out(cen_out), .busy(busy), .done(done), .err(err)
    );

    always #5 cclk = ~cclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [NUM_LUTS+CFG_W-1:0] exp_q[$];
    logic [CFG_W-1:0] words[NUM_LUTS];

    initial begin
        words[0] = 33'h1_0000_FFFF;
        words[1] = 33'h0_AAAA_5555;
        words[2] = 33'h1_1234_8765;
        words[3] = 33'h0_0000_0001;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge cclk);
        cyc++;
    end

    // Monitor: every enable pulse pops one expected {cen, word} entry
    initial begin
        logic [NUM_LUTS-1:0]       prev_cen;
        logic [NUM_LUTS+CFG_W-1:0] e;
        prev_cen = '0;
        forever begin
            @(negedge cclk);
            if (cen_out !== '0) begin
                pulses++;
                chk("cen_onehot", 64'($onehot(cen_out)), 64'd1);
                chk("cen_single_cycle", 64'(prev_cen), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cen_unexpected: got cen=%0h cfg=%0h expected no pulse", cen_out, config_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("cen_target", 64'(cen_out), 64'(e[CFG_W +: NUM_LUTS]));
                    chk("config_word", 64'(config_out), 64'(e[CFG_W-1:0]));
                    chk("split_bit", 64'(config_out[CFG_W-1]), 64'(e[CFG_W-1]));
                end
            end
            prev_cen = cen_out;
        end
    end

    task automatic expect_commit(input int k);
        logic [NUM_LUTS-1:0] c;
        c = NUM_LUTS'(1) << k;
        exp_q.push_back({c, words[k]});
        exp_pulses++;
    endtask

    // Present one bit and hold it until a transfer edge; returns #1 after that edge
    task automatic send_bit(input logic b, input bit gaps);
        int  n;
        logic rdy;
        if (gaps && $urandom_range(1) == 1) begin
            bit_valid = 1'b0;
            bit_in    = ~b;
            @(posedge cclk); #1;
        end
        bit_valid = 1'b1;
        bit_in    = b;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 200) begin
            @(negedge cclk);
            rdy = bit_ready;
            @(posedge cclk); #1;
            n++;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL bit_timeout: got bit_ready=0 for %0d cycles expected 1", n);
        end
    endtask

    task automatic send_word(input logic [CFG_W-1:0] w, input bit gaps, input int glitch_at);
        for (int i = CFG_W - 1; i >= 0; i--) begin
            if (i == glitch_at) start = 1'b1;
            send_bit(w[i], gaps);
            start = 1'b0;
        end
`ifdef LUT_CFG_PARITY_EN
        send_bit(^w, gaps);
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge cclk); #1;
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_done_clr", 64'(done), 64'd0);
        chk("start_err_clr", 64'(err), 64'd0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge cclk); #1;
            n++;
        end
    endtask

    task automatic run_load(input bit gaps, input bit glitch, input bit timed);
        int t0, n;
        do_start();
        t0 = cyc;
        for (int k = 0; k < NUM_LUTS; k++) begin
            expect_commit(k);
            send_word(words[k], gaps, (glitch && k == 1) ? 20 : -1);
            if (glitch && k == 1) begin
                // state is COMMIT here; a start now must be ignored
                bit_valid = 1'b0;
                start     = 1'b1;
                @(posedge cclk); #1;
                start     = 1'b0;
                chk("glitch_busy", 64'(busy), 64'd1);
            end
        end
        bit_valid = 1'b0;
        wait_done(n);
        chk("done_after_last", 64'(n), 64'd1);
        chk("done_flag", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_ready", 64'(bit_ready), 64'd0);
        chk("done_err", 64'(err), 64'd0);
        chk("done_cfg_hold", 64'(config_out), 64'(words[NUM_LUTS-1]));
        if (timed) chk("load_latency", 64'(cyc - t0), 64'(NUM_LUTS * WORD_CYC));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        repeat (2) @(posedge cclk);
        #1;
        chk("rst_cfg", 64'(config_out), 64'd0);
        chk("rst_cen", 64'(cen_out), 64'd0);
        chk("rst_ready", 64'(bit_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(posedge cclk); #1;
        chk("idle_ready", 64'(bit_ready), 64'd0);

        // Abort mid-SHIFT after 10 bits of word 0
        do_start();
        for (int i = CFG_W - 1; i > CFG_W - 11; i--) send_bit(words[0][i], 1'b0);
        chk("partial_cfg", 64'(config_out), 64'h200);
        #2 rst = 1'b1;
        #1;
        chk("abort_cfg", 64'(config_out), 64'd0);
        chk("abort_cen", 64'(cen_out), 64'd0);
        chk("abort_ready", 64'(bit_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        bit_valid = 1'b0;
        @(posedge cclk); #1;
        rst = 1'b0;
        @(posedge cclk); #1;

        run_load(1'b0, 1'b0, 1'b1);   // valid held high
        run_load(1'b1, 1'b0, 1'b0);   // started from DONE, random gaps
        run_load(1'b0, 1'b1, 1'b0);   // start during SHIFT and COMMIT

`ifdef LUT_CFG_PARITY_EN
        // LUT1 word carries a wrong parity bit
        do_start();
        expect_commit(0);
        send_word(words[0], 1'b0, -1);
        for (int i = CFG_W - 1; i >= 0; i--) send_bit(words[1][i], 1'b0);
        send_bit(~(^words[1]), 1'b0);
        bit_valid = 1'b0;
        chk("par_err", 64'(err), 64'd1);
        chk("par_done", 64'(done), 64'd1);
        chk("par_busy", 64'(busy), 64'd0);
        repeat (80) @(posedge cclk);
        #1;
        chk("par_err_sticky", 64'(err), 64'd1);
        run_load(1'b0, 1'b0, 1'b0);
`endif

        repeat (5) @(posedge cclk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("pulse_count", 64'(pulses), 64'(exp_pulses));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
